// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: opcode and immediate-format enums plus the
// helpers that classify an opcode and build its sign-extended immediate.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        OP_IMM = 7'h13,
        OP     = 7'h33,
        LOAD   = 7'h03,
        STORE  = 7'h23,
        BRANCH = 7'h63,
        LUI    = 7'h37,
        AUIPC  = 7'h17,
        JAL    = 7'h6F,
        JALR   = 7'h67
    } opcode_t;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R
    } imm_fmt_t;

    typedef struct packed {
        imm_fmt_t fmt;
        logic     illegal;
    } fmt_info_t;

    function automatic fmt_info_t decode_fmt(input logic [6:0] opc);
        fmt_info_t info;
        info.fmt     = FMT_R;
        info.illegal = 1'b0;
        case (opcode_t'(opc))
            OP_IMM, LOAD, JALR: info.fmt = FMT_I;
            STORE:              info.fmt = FMT_S;
            BRANCH:             info.fmt = FMT_B;
            LUI, AUIPC:         info.fmt = FMT_U;
            JAL:                info.fmt = FMT_J;
            OP:                 info.fmt = FMT_R;
            default:            info.illegal = 1'b1;
        endcase
        return info;
    endfunction

    // Shift-immediates are not special-cased: funct7 stays in imm[11:5].
    function automatic logic [31:0] gen_imm(input imm_fmt_t fmt, input logic [31:0] i);
        logic [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{i[31]}}, i[31:20]};
            FMT_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   imm = {i[31:12], 12'b0};
            FMT_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// x0 reads as zero, every entry cleared by synchronous reset.
module rv_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0][4:0]      raddr,
    output logic [1:0][XLEN-1:0] rdata,
    input  logic                 we,
    input  logic [4:0]           waddr,
    input  logic [XLEN-1:0]      wdata
);

    logic [XLEN-1:0] regs_reg [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_reg[r] <= '0;
            end
        end else if (we && waddr != 5'd0 && int'(waddr) < NREG) begin
            regs_reg[waddr] <= wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            assign rdata[gi] = (raddr[gi] == 5'd0 || int'(raddr[gi]) >= NREG)
                               ? '0 : regs_reg[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode/operand-fetch stage: splits fields, builds the immediate,
// reads operands (with writeback forwarding) and holds the bundle for execute.
module rv_decode_stage #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     idata,
    output logic [31:0]     pc,
    output logic [XLEN-1:0] rv1,
    output logic [XLEN-1:0] rv2,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd_addr,
    output logic            illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);
    import riscv_pkg::*;

    logic            out_valid_reg;
    logic [31:0]     idata_reg, pc_reg;
    logic [XLEN-1:0] rv1_reg, rv2_reg, imm_reg;
    logic [4:0]      rd_addr_reg;
    logic            illegal_reg;

    logic                 accept;
    logic [1:0][4:0]      rs_addr, held_rs;
    logic [1:0][XLEN-1:0] rf_rdata, rv_next;
    logic [1:0]           refresh;
    fmt_info_t            fmt_info;
    logic [31:0]          imm32;

    rv_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .raddr (rs_addr),
        .rdata (rf_rdata),
        .we    (wb_en),
        .waddr (wb_addr),
        .wdata (wb_data)
    );

    assign in_ready   = !out_valid_reg || out_ready;
    assign accept     = in_valid && in_ready && !flush;
    assign rs_addr[0] = in_instr[19:15];
    assign rs_addr[1] = in_instr[24:20];
    assign held_rs[0] = idata_reg[19:15];
    assign held_rs[1] = idata_reg[24:20];

    always_comb begin
        fmt_info = decode_fmt(in_instr[6:0]);
        imm32    = gen_imm(fmt_info.fmt, in_instr);
    end

    // Per operand: forward a same-cycle writeback into the read, and detect a
    // writeback that hits the operand of a stalled bundle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign rv_next[gi] = (BYPASS && wb_en && wb_addr == rs_addr[gi] && rs_addr[gi] != 5'd0)
                                 ? wb_data : rf_rdata[gi];
            assign refresh[gi] = wb_en && wb_addr == held_rs[gi] && held_rs[gi] != 5'd0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            idata_reg     <= '0;
            pc_reg        <= '0;
            rv1_reg       <= '0;
            rv2_reg       <= '0;
            imm_reg       <= '0;
            rd_addr_reg   <= '0;
            illegal_reg   <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            idata_reg     <= in_instr;
            pc_reg        <= in_pc;
            rv1_reg       <= rv_next[0];
            rv2_reg       <= rv_next[1];
            imm_reg       <= XLEN'($signed(imm32));
            rd_addr_reg   <= in_instr[11:7];
            illegal_reg   <= fmt_info.illegal;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end else if (out_valid_reg) begin
            if (refresh[0]) rv1_reg <= wb_data;
            if (refresh[1]) rv2_reg <= wb_data;
        end
    end

    assign out_valid = out_valid_reg;
    assign idata     = idata_reg;
    assign pc        = pc_reg;
    assign rv1       = rv1_reg;
    assign rv2       = rv2_reg;
    assign imm       = imm_reg;
    assign rd_addr   = rd_addr_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed instructions push expected
// bundles; a negedge monitor pops and compares each handshaked bundle.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, idata, pc, rv1, rv2, imm, wb_data;
    logic [4:0]  rd_addr, wb_addr;
    logic        illegal, wb_en;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   pushed = 0;
    int   popped = 0;

    always #5 clk = ~clk;

    rv_decode_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idata     (idata),
        .pc        (pc),
        .rv1       (rv1),
        .rv2       (rv2),
        .imm       (imm),
        .rd_addr   (rd_addr),
        .illegal   (illegal),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    // Offer one instruction for one edge; inputs change at posedge+1.
    task automatic send(input logic [31:0] instr, input logic [31:0] ipc,
                        input logic [31:0] e_rv1, input logic [31:0] e_rv2,
                        input logic [31:0] e_imm, input logic [4:0] e_rd,
                        input logic e_ill, input bit push);
        exp_t e;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = ipc;
        if (push) begin
            e.instr = instr; e.pc = ipc; e.rv1 = e_rv1; e.rv2 = e_rv2;
            e.imm = e_imm; e.rd = e_rd; e.ill = e_ill;
            q.push_back(e);
            pushed++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bundle: got unexpected idata %h pc %h, expected no bundle", idata, pc);
                end else begin
                    e = q.pop_front();
                    popped++;
                    if (idata !== e.instr || pc !== e.pc || rv1 !== e.rv1 || rv2 !== e.rv2 ||
                        imm !== e.imm || rd_addr !== e.rd || illegal !== e.ill) begin
                        fails++;
                        $display("FAIL bundle pc=%h: got idata %h rv1 %h rv2 %h imm %h rd %0d ill %b, expected idata %h rv1 %h rv2 %h imm %h rd %0d ill %b",
                                 e.pc, idata, rv1, rv2, imm, rd_addr, illegal,
                                 e.instr, e.rv1, e.rv2, e.imm, e.rd, e.ill);
                    end else begin
                        $display("[TB] ok bundle pc=%h idata %h imm %h rv1 %h rv2 %h", pc, idata, imm, rv1, rv2);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset idata", idata, 32'd0);
        chk("reset rv1", rv1, 32'd0);
        chk("reset imm", imm, 32'd0);
        chk("reset rd/illegal", {26'd0, rd_addr, illegal}, 32'd0);
        @(posedge clk); #1;

        // addi x1,x0,5 then addi x3,x2,-1 with x2 written the same cycle (bypass)
        send(32'h00500093, 32'h100, 32'h0, 32'h0, 32'h00000005, 5'd1, 1'b0, 1'b1);
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEADBEEF;
        send(32'hFFF10193, 32'h104, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 5'd3, 1'b0, 1'b1);
        wb_en = 1'b0;
        idle(1);

        // add x9,x2,x2 stalled; writeback of x2 refreshes both operands
        out_ready = 1'b0;
        send(32'h002104B3, 32'h108, 32'h12345678, 32'h12345678, 32'h0, 5'd9, 1'b0, 1'b1);
        @(negedge clk);
        chk("stall in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall rv1 before wb", rv1, 32'hDEADBEEF);
        @(posedge clk); #1;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h12345678;
        @(posedge clk); #1;
        wb_en = 1'b0;
        @(negedge clk);
        chk("stall refresh rv1", rv1, 32'h12345678);
        chk("stall refresh rv2", rv2, 32'h12345678);
        chk("stall idata held", idata, 32'h002104B3);
        chk("stall out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("consumed once", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // srai x5,x4,3 : raw I-format immediate keeps funct7 bit
        send(32'h40325293, 32'h10C, 32'h0, 32'h0, 32'h00000403, 5'd5, 1'b0, 1'b1);
        @(negedge clk);
        chk("srai idata[30]", {31'd0, idata[30]}, 32'd1);
        @(posedge clk); #1;
        // sw x2,-4(x1) ; beq x1,x2,+8 ; lui x8,0xABCDE ; jal x1,-2048
        send(32'hFE20AE23, 32'h110, 32'h0, 32'h12345678, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b1);
        send(32'h00208463, 32'h114, 32'h0, 32'h12345678, 32'h00000008, 5'd8, 1'b0, 1'b1);
        send(32'hABCDE437, 32'h118, 32'h0, 32'h0, 32'hABCDE000, 5'd8, 1'b0, 1'b1);
        send(32'h801FF0EF, 32'h11C, 32'h0, 32'h0, 32'hFFFFF800, 5'd1, 1'b0, 1'b1);

        // writes to x0 are ignored
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        idle(1);
        wb_en = 1'b0;
        send(32'h00000313, 32'h120, 32'h0, 32'h0, 32'h0, 5'd6, 1'b0, 1'b1);
        // unsupported opcode
        send(32'h0000007F, 32'h124, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
        idle(1);

        // flush blocks an incoming instruction
        flush = 1'b1;
        send(32'h00500093, 32'h128, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        chk("flush incoming out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // flush drops a held bundle
        out_ready = 1'b0;
        send(32'h00000313, 32'h12C, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("held before flush", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush held out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        idle(4);
        chk("scoreboard empty", q.size(), 32'd0);
        chk("bundles consumed", popped, pushed);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Producer end of the execute-unit bus: a registered decode/operand-fetch stage that feeds I-type and other execute units.
- Accepts fetched instructions over a valid/ready handshake and splits out fields.
- Generates the sign-extended immediate and reads rs1/rs2 from an internal register file.
- Presents idata/rv1/rv2/imm in a pipeline register; owns the register-file write port that consumes execute results (regdata).

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural register count (x0 hardwired zero)
BYPASS, 1, 1 = same-cycle writeback forwarded into operand read

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
flush  in  1  discard held and incoming instruction
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction
in_pc  in  32  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
idata  out  32  registered raw instruction (execute reads funct3/bit30)
pc  out  32  registered pc
rv1  out  32  rs1 value
rv2  out  32  rs2 value
imm  out  32  sign-extended immediate
rd_addr  out  5  destination register
illegal  out  1  unsupported opcode
wb_en  in  1  writeback enable
wb_addr  in  5  writeback register
wb_data  in  32  writeback value (regdata from execute)

Behaviour:
- Reset (synchronous): out_valid, idata, pc, rv1, rv2, imm, rd_addr, illegal all 0; all registers cleared to 0; in_ready = 1 the cycle after reset deasserts.
- in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready.
- On accept: register all outputs; out_valid = 1 next cycle. Latency is exactly 1 cycle.
- Output held stable while out_valid && !out_ready.
- On out_valid && out_ready && !accept: out_valid = 0.
- flush priority: flush=1 forces out_valid=0 next cycle and blocks accept; other output regs may keep stale values.
- Immediate by opcode[6:0]:
  - I (0x13, 0x03, 0x67): {20{i[31]}, i[31:20]}
  - S (0x23): {20{i[31]}, i[31:25], i[11:7]}
  - B (0x63): {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - U (0x37, 0x17): {i[31:12], 12'b0}
  - J (0x6F): {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
  - R (0x33): imm = 0
  - Any other opcode: imm = 0, illegal = 1.
- Shift-immediate (funct3 001/101): imm is the raw I-format value, e.g. SRAI keeps 0x400 | shamt; idata[30] is passed through unchanged.
- Register file:
  - Writes on wb_en && wb_addr != 0.
  - Reads of x0 always return 0.
  - NREG entries.
- Bypass (BYPASS=1): if accept and wb_en and wb_addr == rs != 0, the operand captured is wb_data rather than the stale array value.
- Stall refresh: while out_valid && !out_ready, a writeback matching a held rs1/rs2 field (nonzero) updates the held rv1/rv2 to wb_data. Both update if rs1 == rs2.
- Writeback and flush are independent: a writeback is never dropped by flush or stall.
- Reset mid-transfer: bundle dropped; no writeback occurs in the reset cycle.

Decomposition:
- riscv_pkg gains:
  - opcode_t enum (OP_IMM, OP, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR)
  - imm_fmt_t enum (FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R)
  - XLEN constant
- Sub-module rv_regfile:
  - 2 combinational read ports, 1 synchronous write port, x0 zero, synchronous reset clear.
  - Bypass and refresh logic stay in rv_decode_stage.

Test Plan:
- Reset, then in_instr=0x00500093 (addi x1,x0,5), in_valid=1 -> next cycle out_valid=1, imm=0x00000005, rv1=0, rd_addr=1, illegal=0.
- wb x2=0xDEADBEEF in same cycle as accepting 0xFFF10193 (addi x3,x2,-1) -> rv1=0xDEADBEEF, imm=0xFFFFFFFF.
- Hold out_ready=0 with bundle rs1=x2, then wb x2=0x12345678 -> rv1 becomes 0x12345678, in_ready=0, idata unchanged; release -> bundle consumed once.
- in_instr=0x40325293 (srai x5,x4,3) -> imm=0x00000403, idata[30]=1, rd_addr=5.
- wb x0=0xFFFFFFFF, then decode addi x6,x0,0 -> rv1=0.
- flush=1 with in_valid=1 -> out_valid=0 next cycle, instruction dropped. Separately, in_instr=0x0000007F -> illegal=1, imm=0.
